timer_prescaler: RTL and testbench

- Parametrised clock-enable prescaler for the APB timer family. Successor to the toggle-output clock divider.
- Produces a single-PCLK-cycle tick_o that qualifies the timer counter, so the timer stays in the PCLK domain and has no derived clock.
- Supports power-of-two internal division plus synchronised external-clock edge modes, selected by a CKS field.
- Also provides a legacy 50%-duty toggle output.

---
 rtl/timer_prescaler_if.sv | 23 ++
 rtl/timer_prescaler.sv | 87 ++++++++
 tb/tb_timer_prescaler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/timer_prescaler_if.sv
// Signal bundle between the timer core and its clock-enable prescaler.
// The timer core drives the master side; the prescaler uses the slave side.
interface timer_prescaler_if #(
    parameter int DIV_W = 8,
    parameter int SEL_W = 3
);
    logic             en_i;
    logic [SEL_W-1:0] cks_i;
    logic             ext_clk_i;
    logic             tick_o;
    logic             clk_out_o;
    logic [DIV_W-1:0] presc_cnt_o;

    modport master (
        output en_i, cks_i, ext_clk_i,
        input  tick_o, clk_out_o, presc_cnt_o
    );

    modport slave (
        input  en_i, cks_i, ext_clk_i,
        output tick_o, clk_out_o, presc_cnt_o
    );
endinterface

// File: rtl/timer_prescaler.sv
// Clock-enable prescaler: power-of-two internal division or synchronised external
// edges produce a one-cycle tick in the PCLK domain, plus a legacy toggle output.
module timer_prescaler #(
    parameter int DIV_W = 8,
    parameter int SEL_W = 3
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    timer_prescaler_if.slave   bus
);
    localparam int NCODE = 1 << SEL_W;
    localparam int NI    = NCODE - 3;

    localparam logic [SEL_W-1:0] CODE_RISE = SEL_W'(NI);
    localparam logic [SEL_W-1:0] CODE_FALL = SEL_W'(NI + 1);

    // The largest internal code must fit inside the counter.
    if (DIV_W < NCODE - 4) begin : g_param_check
        $error("timer_prescaler: DIV_W must be at least 2**SEL_W-4");
    end

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;
    logic [SEL_W-1:0] cks_q;
    logic             s1_q, s2_q, s3_q;

    logic [DIV_W-1:0] div_mask;
    logic             rise, fall, ext_edge;

    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign div_mask = (DIV_W'(1) << cks_q) - DIV_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        ext_edge = 1'b0;

        if (bus.cks_i != cks_q) begin
            cnt_d = '0;
        end else if (cks_q < CODE_RISE) begin
            if (bus.en_i) begin
                tick_d = &(cnt_q | ~div_mask);
                cnt_d  = cnt_q + DIV_W'(1);
            end
        end else begin
            case (cks_q)
                CODE_RISE: ext_edge = rise;
                CODE_FALL: ext_edge = fall;
                default:   ext_edge = rise | fall;
            endcase
            tick_d = bus.en_i & ext_edge;
            if (tick_d) begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        clk_out_d = clk_out_q ^ tick_d;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
            cks_q     <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, which the synchroniser chain depends on.
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
            cks_q     <= bus.cks_i;
            s1_q      <= bus.ext_clk_i;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
        end
    end

    assign bus.tick_o      = tick_q;
    assign bus.clk_out_o   = clk_out_q;
    assign bus.presc_cnt_o = cnt_q;
endmodule

// File: tb/tb_timer_prescaler.sv
// Self-checking bench for timer_prescaler: directed phases plus randomised traffic,
// compared every cycle against a cycle-level behavioural model of the prescaler rules.
module tb_timer_prescaler;
    localparam int DIV_W = 8;
    localparam int SEL_W = 3;
    localparam int NI    = (1 << SEL_W) - 3;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    int n_cmp     = 0;
    int n_err     = 0;
    int tick_seen = 0;

    timer_prescaler_if #(.DIV_W(DIV_W), .SEL_W(SEL_W)) bus ();

    timer_prescaler #(.DIV_W(DIV_W), .SEL_W(SEL_W)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    // Behavioural model state: counter as a plain integer, ext samples as a history queue.
    int m_cnt;
    bit m_tick;
    bit m_clk;
    int m_cks_q;
    bit m_hist[$];

    function automatic void model_reset();
        m_cnt   = 0;
        m_tick  = 1'b0;
        m_clk   = 1'b0;
        m_cks_q = 0;
        m_hist  = {1'b0, 1'b0, 1'b0};
    endfunction

    // One rising edge; m_hist[1]/m_hist[2] are the ext samples taken two and three edges ago.
    function automatic void model_step();
        int code;
        int period;
        bit r, f, ev;
        code = int'(bus.cks_i);
        if (code != m_cks_q) begin
            m_tick = 1'b0;
            m_cnt  = 0;
        end else if (code < NI) begin
            if (bus.en_i) begin
                period = 1 << code;
                m_tick = ((m_cnt % period) == period - 1);
                m_cnt  = (m_cnt + 1) % (1 << DIV_W);
            end else begin
                m_tick = 1'b0;
            end
        end else begin
            r  = m_hist[1] && !m_hist[2];
            f  = !m_hist[1] && m_hist[2];
            ev = (code == NI) ? r : (code == NI + 1) ? f : (r || f);
            m_tick = bus.en_i && ev;
            if (m_tick) m_cnt = (m_cnt + 1) % (1 << DIV_W);
        end
        if (m_tick) m_clk = !m_clk;
        m_cks_q = code;
        m_hist.push_front(bus.ext_clk_i);
        void'(m_hist.pop_back());
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic compare();
        check("tick_o", 32'(bus.tick_o), 32'(m_tick));
        check("clk_out_o", 32'(bus.clk_out_o), 32'(m_clk));
        check("presc_cnt_o", 32'(bus.presc_cnt_o), 32'(m_cnt));
        if (bus.tick_o === 1'b1) tick_seen++;
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            if (PRESETn) model_step();
            @(negedge PCLK);
            compare();
        end
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_tick"}, 32'(bus.tick_o), 32'd0);
        check({tag, "_clk"}, 32'(bus.clk_out_o), 32'd0);
        check({tag, "_cnt"}, 32'(bus.presc_cnt_o), 32'd0);
    endtask

    initial begin
        int hold;
        bus.en_i      = 1'b0;
        bus.cks_i     = '0;
        bus.ext_clk_i = 1'b0;
        model_reset();

        // Reset held: all outputs zero.
        @(negedge PCLK);
        check_reset_zero("por");
        cycle(2);
        check_reset_zero("por_held");
        PRESETn = 1'b1;

        // Divide by 8.
        bus.en_i  = 1'b1;
        bus.cks_i = SEL_W'(3);
        cycle(30);

        // Divide by 1, then pause and resume without phase reset.
        bus.cks_i = SEL_W'(0);
        cycle(5);
        bus.en_i = 1'b0;
        cycle(4);
        bus.en_i = 1'b1;
        cycle(3);

        // Divide by 16, switch to divide by 2 at cnt 9.
        bus.cks_i = SEL_W'(4);
        cycle(10);
        bus.cks_i = SEL_W'(1);
        cycle(10);

        // External rising edge: one 4-cycle pulse.
        bus.cks_i = SEL_W'(5);
        cycle(6);
        bus.ext_clk_i = 1'b1;
        cycle(4);
        bus.ext_clk_i = 1'b0;
        cycle(8);

        // External both edges with a 4-high/4-low clock, then falling-edge mode.
        bus.cks_i = SEL_W'(7);
        for (int k = 0; k < 12; k++) begin
            bus.ext_clk_i = 1'((k + 1) % 2);
            cycle(4);
        end
        bus.cks_i = SEL_W'(6);
        for (int k = 0; k < 6; k++) begin
            bus.ext_clk_i = 1'((k + 1) % 2);
            cycle(3);
        end
        bus.ext_clk_i = 1'b0;
        cycle(2);

        // Divide by 16 across the counter wrap: after the select-change edge, 304 edges give 19 ticks.
        bus.cks_i = SEL_W'(4);
        cycle(1);
        tick_seen = 0;
        cycle(304);
        check("wrap_ticks", 32'(tick_seen), 32'd19);

        // Asynchronous reset while a tick is pending.
        bus.cks_i = SEL_W'(0);
        cycle(4);
        PRESETn = 1'b0;
        model_reset();
        #1;
        check_reset_zero("mid_rst");
        cycle(2);
        PRESETn = 1'b1;
        cycle(6);
        bus.cks_i = SEL_W'(2);
        cycle(12);

        // Randomised traffic across all modes, including short ext pulses.
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) bus.cks_i = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
            bus.en_i = ($urandom_range(0, 7) != 0);
            if (hold == 0) begin
                bus.ext_clk_i = ~bus.ext_clk_i;
                hold = $urandom_range(1, 6);
            end
            hold--;
            cycle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
